// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS subset datapath controllers: opcode/funct
// constants, ALU control codes, mux encodings and the multicycle state set.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_REG     = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWR  = 4'd4,
    S_MEMWB  = 4'd5,
    S_RDEXEC = 4'd6,
    S_RWB    = 4'd7,
    S_IEXEC  = 4'd8,
    S_IWB    = 4'd9,
    S_BRANCH = 4'd10,
    S_JUMP   = 4'd11
  } state_e;

endpackage

// File: rtl/mips_mc_ctrl_if.sv
// Control bundle between the multicycle controller (master) and the datapath
// (slave): decoded IR fields and flags in, mux selects and strobes out.
interface mips_mc_ctrl_if #(parameter int OP_W = 6);

  logic [OP_W-1:0] opcode;
  logic [OP_W-1:0] funct;
  logic            zero;
  logic            mem_ready;

  logic            mem_req;
  logic            iord;
  logic            mem_write;
  logic            ir_write;
  logic            pc_write;
  logic            pc_write_cond;
  logic [1:0]      pc_src;
  logic            alu_src_a;
  logic [1:0]      alu_src_b;
  logic [2:0]      alu_ctrl;
  logic            reg_dst;
  logic            mem_to_reg;
  logic            reg_write;
  logic            illegal;
  logic [3:0]      state;

  modport master (
    input  opcode, funct, zero, mem_ready,
    output mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
           reg_write, illegal, state
  );

  modport slave (
    output opcode, funct, zero, mem_ready,
    input  mem_req, iord, mem_write, ir_write, pc_write, pc_write_cond,
           pc_src, alu_src_a, alu_src_b, alu_ctrl, reg_dst, mem_to_reg,
           reg_write, illegal, state
  );

endinterface

// File: rtl/mips_alu_dec.sv
// R-type funct decoder: maps funct to an ALU control code and flags codes
// outside the supported subset. Shared with the single-cycle datapath.
module mips_alu_dec
  import mips_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic [OP_W-1:0] funct,
  output logic [2:0]      alu_ctrl,
  output logic            valid
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    valid    = 1'b1;
    case (funct)
      FN_ADD:  alu_ctrl = ALU_ADD;
      FN_SUB:  alu_ctrl = ALU_SUB;
      FN_AND:  alu_ctrl = ALU_AND;
      FN_OR:   alu_ctrl = ALU_OR;
      FN_SLT:  alu_ctrl = ALU_SLT;
      default: valid    = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multicycle MIPS control FSM: steps each instruction through fetch, decode,
// execute, memory and write-back, stalling on the shared memory handshake.
module mips_mc_ctrl
  import mips_pkg::*;
#(
  parameter int OP_W = 6
) (
  input  logic           clk,
  input  logic           rst,
  mips_mc_ctrl_if.master bus
);

  state_e     state_q, state_d;
  logic       illegal_q, illegal_d;
  logic       is_store_q, is_store_d;
  logic [2:0] fn_ctrl;
  logic       fn_valid;

  mips_alu_dec #(.OP_W(OP_W)) u_alu_dec (
    .funct    (bus.funct),
    .alu_ctrl (fn_ctrl),
    .valid    (fn_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_FETCH;
      illegal_q  <= 1'b0;
      is_store_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      illegal_q  <= illegal_d;
      is_store_q <= is_store_d;
    end
  end

  // Load vs store is latched in DECODE so the opcode is never looked at in MEMADR.
  always_comb begin
    state_d    = state_q;
    illegal_d  = 1'b0;
    is_store_d = is_store_q;

    bus.mem_req       = 1'b0;
    bus.iord          = 1'b0;
    bus.mem_write     = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.pc_write_cond = 1'b0;
    bus.pc_src        = PC_SRC_ALU;
    bus.alu_src_a     = 1'b0;
    bus.alu_src_b     = SRCB_REG;
    bus.alu_ctrl      = ALU_AND;
    bus.reg_dst       = 1'b0;
    bus.mem_to_reg    = 1'b0;
    bus.reg_write     = 1'b0;

    case (state_q)
      S_FETCH: begin
        bus.mem_req   = 1'b1;
        bus.alu_src_b = SRCB_FOUR;
        bus.alu_ctrl  = ALU_ADD;
        bus.ir_write  = bus.mem_ready;
        bus.pc_write  = bus.mem_ready;
        if (bus.mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        bus.alu_src_b = SRCB_IMM_SH2;
        bus.alu_ctrl  = ALU_ADD;
        is_store_d    = (bus.opcode == OP_SW);
        case (bus.opcode)
          OP_LW, OP_SW: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RDEXEC;
          OP_ADDI:      state_d = S_IEXEC;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default: begin
            state_d   = S_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      S_MEMADR, S_IEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_src_b = SRCB_IMM;
        bus.alu_ctrl  = ALU_ADD;
        if (state_q == S_IEXEC) state_d = S_IWB;
        else                    state_d = is_store_q ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        bus.mem_req = 1'b1;
        bus.iord    = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWR: begin
        bus.mem_req   = 1'b1;
        bus.iord      = 1'b1;
        bus.mem_write = bus.mem_ready;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_MEMWB: begin
        bus.reg_write  = 1'b1;
        bus.mem_to_reg = 1'b1;
        state_d        = S_FETCH;
      end
      // An unsupported funct still drives add but never reaches write-back.
      S_RDEXEC: begin
        bus.alu_src_a = 1'b1;
        bus.alu_ctrl  = fn_ctrl;
        if (fn_valid) begin
          state_d = S_RWB;
        end else begin
          state_d   = S_FETCH;
          illegal_d = 1'b1;
        end
      end
      S_RWB: begin
        bus.reg_write = 1'b1;
        bus.reg_dst   = 1'b1;
        state_d       = S_FETCH;
      end
      S_IWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a     = 1'b1;
        bus.alu_ctrl      = ALU_SUB;
        bus.pc_write_cond = 1'b1;
        bus.pc_src        = PC_SRC_ALUOUT;
        state_d           = S_FETCH;
      end
      S_JUMP: begin
        bus.pc_write = 1'b1;
        bus.pc_src   = PC_SRC_JUMP;
        state_d      = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;

endmodule

// File: tb/tb_mips_mc_ctrl.sv
// Self-checking bench for mips_mc_ctrl: per-instruction step traces built from
// the instruction class, compared every cycle, plus hand-computed spot checks.
module tb_mips_mc_ctrl;
  import mips_pkg::*;

  typedef struct packed {
    logic [3:0] state;
    logic       mem_req;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_ctrl;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       illegal;
  } out_t;

  typedef struct {
    state_e     st;
    bit         rdy;
    logic [5:0] op;
    logic [5:0] fn;
    bit         ill;
    string      label;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;
  bit   pend_illegal = 1'b0;
  rec_t trace[$];
  rec_t exp_q[$];
  out_t log_q[$];
  rec_t cur;

  mips_mc_ctrl_if #(.OP_W(6)) bus ();

  mips_mc_ctrl #(.OP_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  function automatic out_t sample();
    out_t o;
    o.state         = bus.state;
    o.mem_req       = bus.mem_req;
    o.iord          = bus.iord;
    o.mem_write     = bus.mem_write;
    o.ir_write      = bus.ir_write;
    o.pc_write      = bus.pc_write;
    o.pc_write_cond = bus.pc_write_cond;
    o.pc_src        = bus.pc_src;
    o.alu_src_a     = bus.alu_src_a;
    o.alu_src_b     = bus.alu_src_b;
    o.alu_ctrl      = bus.alu_ctrl;
    o.reg_dst       = bus.reg_dst;
    o.mem_to_reg    = bus.mem_to_reg;
    o.reg_write     = bus.reg_write;
    o.illegal       = bus.illegal;
    return o;
  endfunction

  function automatic logic [2:0] aluFor(input logic [5:0] fn);
    case (fn)
      6'h22:   return 3'b110;
      6'h24:   return 3'b000;
      6'h25:   return 3'b001;
      6'h2A:   return 3'b111;
      default: return 3'b010;
    endcase
  endfunction

  function automatic bit functOk(input logic [5:0] fn);
    return (fn == 6'h20) || (fn == 6'h22) || (fn == 6'h24) || (fn == 6'h25) || (fn == 6'h2A);
  endfunction

  // Output table: what each step must drive, zero for anything unlisted.
  function automatic out_t expectOut(input state_e s, input bit rdy, input logic [5:0] fn, input bit ill);
    out_t o;
    o = '0;
    o.state   = s;
    o.illegal = ill;
    case (s)
      S_FETCH: begin
        o.mem_req = 1; o.alu_src_b = 2'b01; o.alu_ctrl = 3'b010;
        o.ir_write = rdy; o.pc_write = rdy;
      end
      S_DECODE: begin o.alu_src_b = 2'b11; o.alu_ctrl = 3'b010; end
      S_MEMADR, S_IEXEC: begin o.alu_src_a = 1; o.alu_src_b = 2'b10; o.alu_ctrl = 3'b010; end
      S_MEMRD: begin o.mem_req = 1; o.iord = 1; end
      S_MEMWR: begin o.mem_req = 1; o.iord = 1; o.mem_write = rdy; end
      S_MEMWB: begin o.reg_write = 1; o.mem_to_reg = 1; end
      S_RDEXEC: begin o.alu_src_a = 1; o.alu_ctrl = aluFor(fn); end
      S_RWB: begin o.reg_write = 1; o.reg_dst = 1; end
      S_IWB: o.reg_write = 1;
      S_BRANCH: begin o.alu_src_a = 1; o.alu_ctrl = 3'b110; o.pc_write_cond = 1; o.pc_src = 2'b01; end
      S_JUMP: begin o.pc_write = 1; o.pc_src = 2'b10; end
      default: o = '0;
    endcase
    return o;
  endfunction

  task automatic addRec(input state_e s, input bit rdy, input logic [5:0] op, input logic [5:0] fn, input string label);
    rec_t r;
    r.st = s; r.rdy = rdy; r.op = op; r.fn = fn; r.label = label;
    r.ill = pend_illegal;
    pend_illegal = 1'b0;
    trace.push_back(r);
  endtask

  // Step list per instruction class, with wait cycles inserted where memory stalls.
  task automatic buildTrace(input logic [31:0] instr, input int fetch_wait, input int mem_wait, input string tag);
    logic [5:0] op, fn;
    op = instr[31:26];
    fn = instr[5:0];
    for (int i = 0; i < fetch_wait; i++) addRec(S_FETCH, 1'b0, 6'h3F, 6'h3F, {tag, "/fetch_wait"});
    addRec(S_FETCH, 1'b1, op, fn, {tag, "/fetch"});
    addRec(S_DECODE, 1'b1, op, fn, {tag, "/decode"});
    if (op == 6'h23) begin
      addRec(S_MEMADR, 1'b1, op, fn, {tag, "/memadr"});
      for (int i = 0; i < mem_wait; i++) addRec(S_MEMRD, 1'b0, op, fn, {tag, "/memrd_wait"});
      addRec(S_MEMRD, 1'b1, op, fn, {tag, "/memrd"});
      addRec(S_MEMWB, 1'b1, op, fn, {tag, "/memwb"});
    end else if (op == 6'h2B) begin
      addRec(S_MEMADR, 1'b1, op, fn, {tag, "/memadr"});
      for (int i = 0; i < mem_wait; i++) addRec(S_MEMWR, 1'b0, op, fn, {tag, "/memwr_wait"});
      addRec(S_MEMWR, 1'b1, op, fn, {tag, "/memwr"});
    end else if (op == 6'h00) begin
      addRec(S_RDEXEC, 1'b1, op, fn, {tag, "/rdexec"});
      if (functOk(fn)) addRec(S_RWB, 1'b1, op, fn, {tag, "/rwb"});
      else             pend_illegal = 1'b1;
    end else if (op == 6'h08) begin
      addRec(S_IEXEC, 1'b1, op, fn, {tag, "/iexec"});
      addRec(S_IWB, 1'b1, op, fn, {tag, "/iwb"});
    end else if (op == 6'h04) begin
      addRec(S_BRANCH, 1'b1, op, fn, {tag, "/branch"});
    end else if (op == 6'h02) begin
      addRec(S_JUMP, 1'b1, op, fn, {tag, "/jump"});
    end else begin
      pend_illegal = 1'b1;
    end
  endtask

  task automatic applyStimulus();
    log_q.delete();
    foreach (trace[i]) begin
      @(posedge clk);
      #1;
      bus.opcode    = trace[i].op;
      bus.funct     = trace[i].fn;
      bus.mem_ready = trace[i].rdy;
      exp_q.push_back(trace[i]);
    end
    trace.delete();
    @(negedge clk);
    #1;
  endtask

  task automatic runInstr(input logic [31:0] instr, input int fetch_wait, input int mem_wait, input string tag);
    buildTrace(instr, fetch_wait, mem_wait, tag);
    applyStimulus();
  endtask

  function automatic int latency();
    int n = 1;
    foreach (log_q[i]) if (log_q[i].state != 4'd0) n++;
    return n;
  endfunction

  always @(negedge clk) begin
    if (rst && exp_q.size() > 0) begin
      out_t act, expv;
      cur  = exp_q.pop_front();
      act  = sample();
      expv = expectOut(cur.st, cur.rdy, cur.fn, cur.ill);
      log_q.push_back(act);
      checkOutput(cur.label, 32'(act), 32'(expv));
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int cnt_a, cnt_b, cnt_c;
    bus.opcode = 6'h00; bus.funct = 6'h00; bus.zero = 1'b0; bus.mem_ready = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("reset_state", bus.state, 0);
    checkOutput("reset_mem_req", bus.mem_req, 1);
    checkOutput("reset_ir_write", bus.ir_write, 0);
    checkOutput("reset_pc_write", bus.pc_write, 0);
    checkOutput("reset_illegal", bus.illegal, 0);
    checkOutput("reset_alu_src_b", bus.alu_src_b, 2'b01);
    rst = 1'b1;

    runInstr(32'h2109000A, 0, 0, "addi");
    checkOutput("addi_latency", latency(), 4);
    checkOutput("addi_iwb_reg_write", log_q[3].reg_write, 1);
    checkOutput("addi_iwb_reg_dst", log_q[3].reg_dst, 0);
    checkOutput("addi_iwb_mem_to_reg", log_q[3].mem_to_reg, 0);

    runInstr(32'h01494820, 0, 0, "add");
    checkOutput("add_rdexec_alu_ctrl", log_q[2].alu_ctrl, 3'b010);
    checkOutput("add_rwb_reg_dst", log_q[3].reg_dst, 1);
    checkOutput("add_rwb_reg_write", log_q[3].reg_write, 1);
    runInstr(32'h01494822, 1, 0, "sub");
    checkOutput("sub_rdexec_alu_ctrl", log_q[3].alu_ctrl, 3'b110);
    runInstr(32'h01494824, 0, 0, "and");
    runInstr(32'h01494825, 0, 0, "or");
    runInstr(32'h0149482A, 0, 0, "slt");
    checkOutput("slt_rdexec_alu_ctrl", log_q[2].alu_ctrl, 3'b111);

    runInstr(32'h8D4C0008, 0, 2, "lw");
    checkOutput("lw_latency", latency(), 7);
    cnt_a = 0;
    for (int i = 3; i <= 5; i++) if (log_q[i].iord && log_q[i].mem_req && log_q[i].state == 4'd3) cnt_a++;
    checkOutput("lw_stall_iord_mem_req", cnt_a, 3);
    checkOutput("lw_memwb_mem_to_reg", log_q[6].mem_to_reg, 1);

    runInstr(32'hAD4B000A, 0, 0, "sw");
    checkOutput("sw_latency", latency(), 4);
    runInstr(32'hAD4B000A, 2, 1, "sw_stall");
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      cnt_a += log_q[i].mem_write;
      cnt_b += log_q[i].reg_write;
    end
    checkOutput("sw_mem_write_pulses", cnt_a, 1);
    checkOutput("sw_reg_write_count", cnt_b, 0);

    runInstr(32'h1109FFFF, 0, 0, "beq");
    checkOutput("beq_latency", latency(), 3);
    runInstr(32'h08000010, 0, 0, "j");
    checkOutput("j_latency", latency(), 3);

    runInstr(32'hFC000000, 0, 0, "bad_op");
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      cnt_a += log_q[i].illegal;
      cnt_b += log_q[i].reg_write + log_q[i].mem_write + log_q[i].pc_write_cond;
    end
    runInstr(32'h08000010, 0, 0, "j_after_bad_op");
    cnt_c = 0;
    foreach (log_q[i]) cnt_c += log_q[i].illegal;
    checkOutput("bad_op_illegal_pulses", cnt_a + cnt_c, 1);
    checkOutput("bad_op_illegal_first_fetch", log_q[0].illegal, 1);
    checkOutput("bad_op_no_strobes", cnt_b, 0);

    runInstr(32'h0149483F, 0, 0, "bad_fn");
    cnt_a = 0; cnt_b = 0;
    foreach (log_q[i]) begin
      cnt_a += log_q[i].illegal;
      cnt_b += log_q[i].reg_write + log_q[i].mem_write + log_q[i].pc_write_cond;
    end
    runInstr(32'h2109000A, 0, 0, "addi_after_bad_fn");
    cnt_c = 0;
    foreach (log_q[i]) cnt_c += log_q[i].illegal;
    checkOutput("bad_fn_illegal_pulses", cnt_a + cnt_c, 1);
    checkOutput("bad_fn_no_strobes", cnt_b, 0);

    addRec(S_FETCH, 1'b1, 6'h2B, 6'h0A, "sw_abort/fetch");
    addRec(S_DECODE, 1'b1, 6'h2B, 6'h0A, "sw_abort/decode");
    addRec(S_MEMADR, 1'b1, 6'h2B, 6'h0A, "sw_abort/memadr");
    addRec(S_MEMWR, 1'b1, 6'h2B, 6'h0A, "sw_abort/memwr");
    applyStimulus();
    checkOutput("abort_mem_write_before", bus.mem_write, 1);
    rst = 1'b0;
    #1;
    checkOutput("abort_mem_write_dropped", bus.mem_write, 0);
    checkOutput("abort_state_fetch", bus.state, 0);
    checkOutput("abort_mem_req", bus.mem_req, 1);
    pend_illegal = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.mem_ready = 1'b0;
    rst = 1'b1;
    runInstr(32'h08000010, 1, 0, "j_after_abort");
    checkOutput("resume_ir_write", log_q[1].ir_write, 1);
    checkOutput("resume_pc_write", log_q[1].pc_write, 1);
    checkOutput("resume_wait_ir_write", log_q[0].ir_write, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
